// File: rtl/riscv_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_dbg_pkg
// Purpose : Shared definitions for the RV32Core BRAM debug agent: command
//           opcode encodings, FSM state encoding, default BRAM depth and the
//           command-length clamp helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package riscv_dbg_pkg;

  localparam int BRAMWORDS = 4096;

  localparam logic [1:0] DBG_LOAD = 2'b00;
  localparam logic [1:0] DBG_DUMP = 2'b01;
  localparam logic [1:0] DBG_RUN  = 2'b10;
  localparam logic [1:0] DBG_RSVD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_DUMP_ADDR = 4'd2,
    ST_DUMP_WAIT = 4'd3,
    ST_DUMP_OUT  = 4'd4,
    ST_RUN_RST   = 4'd5,
    ST_RUN_EXEC  = 4'd6,
    ST_FINISH    = 4'd7
  } dbg_state_e;

  // Limit a requested word count to the BRAM depth so addresses never wrap.
  function automatic logic [12:0] clamp_len(input logic [12:0] len,
                                            input logic [12:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_word_counter.sv
`default_nettype none
// ============================================================================
// Module  : dbg_word_counter
// Purpose : Clearable up-counter with a terminal-value compare. Used for the
//           LOAD/DUMP word count and for the RUN reset/execute cycle counts.
// Ports   : clk_i    - clock
//           rst_ni   - asynchronous active-low reset
//           clr_i    - synchronous clear (has priority over inc_i)
//           inc_i    - increment by one
//           term_i   - terminal value
//           last_o   - high while the count equals term_i
// Revision: 1.0 - initial release
// ============================================================================
module dbg_word_counter #(
  parameter int WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == term_i);

endmodule
`default_nettype wire

// File: rtl/bram_debug_agent.sv
`default_nettype none
// ============================================================================
// Module  : bram_debug_agent
// Purpose : Host for the RV32Core BRAM debug ports. Executes LOAD (bulk
//           write), DUMP (bulk read) and RUN (core reset pulse plus fixed
//           execution window) commands received over valid/ready streams.
// Ports   : CPU_CLK, CPU_RST_N            - clock, async active-low reset
//           cmd_valid/ready, cmd_op/sel/len - command stream
//           in_valid/ready, in_data       - LOAD word stream
//           out_valid/ready, out_data     - DUMP word stream
//           CPU_Debug_DataRAM_A2/WD2/WE2/RD2 - DataRAM debug port
//           CPU_Debug_InstRAM_A2/WD2/WE2/RD2 - InstRAM debug port
//           CPU_Core_RST                  - active-high core reset
//           busy, done                    - status (done is a 1-cycle pulse)
// Revision: 1.0 - initial release
// ============================================================================
module bram_debug_agent
  import riscv_dbg_pkg::*;
#(
  parameter int BRAM_WORDS = BRAMWORDS,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 200000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_sel,
  input  logic [12:0] cmd_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2,
  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2,
  output logic        CPU_Core_RST,
  output logic        busy,
  output logic        done
);

  localparam int CYC_MAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [12:0]      LEN_MAX  = 13'(BRAM_WORDS);
  localparam logic [CYC_W-1:0] RST_TERM = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] RUN_TERM = CYC_W'(RUN_CYCLES - 1);

  dbg_state_e state_q, state_d;

  logic        sel_q;
  logic [12:0] len_q;
  logic [31:0] addr_q;
  logic [31:0] out_data_q;
  logic [31:0] d_a2_q, d_wd_q, i_a2_q, i_wd_q;
  logic [3:0]  d_we_q, i_we_q;

  logic        w_cmd_fire, w_in_fire, w_out_fire;
  logic [12:0] w_len;
  logic        w_word_last, w_cyc_last;
  logic        w_a2_load, w_wr, w_sel;
  logic [31:0] w_a2_val;

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_len      = clamp_len(cmd_len, LEN_MAX);

  // Word counter: terminal at len'-1, so last_o flags the final word's handshake.
  dbg_word_counter #(.WIDTH(13)) u_word_cnt (
    .clk_i  (CPU_CLK),
    .rst_ni (CPU_RST_N),
    .clr_i  (w_cmd_fire),
    .inc_i  (w_in_fire || w_out_fire),
    .term_i (len_q - 13'd1),
    .last_o (w_word_last)
  );

  // Cycle counter: reused for the reset window then restarted for the run window.
  dbg_word_counter #(.WIDTH(CYC_W)) u_cyc_cnt (
    .clk_i  (CPU_CLK),
    .rst_ni (CPU_RST_N),
    .clr_i  (w_cmd_fire || ((state_q == ST_RUN_RST) && w_cyc_last)),
    .inc_i  ((state_q == ST_RUN_RST) || (state_q == ST_RUN_EXEC)),
    .term_i ((state_q == ST_RUN_EXEC) ? RUN_TERM : RST_TERM),
    .last_o (w_cyc_last)
  );

  // State register
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            DBG_LOAD: state_d = (w_len == 13'd0) ? ST_FINISH : ST_LOAD;
            DBG_DUMP: state_d = (w_len == 13'd0) ? ST_FINISH : ST_DUMP_ADDR;
            DBG_RUN:  state_d = ST_RUN_RST;
            default:  state_d = ST_FINISH;
          endcase
        end
      end
      ST_LOAD:      if (w_in_fire && w_word_last) state_d = ST_FINISH;
      ST_DUMP_ADDR: state_d = ST_DUMP_WAIT;
      ST_DUMP_WAIT: state_d = ST_DUMP_OUT;
      ST_DUMP_OUT:  if (w_out_fire) state_d = w_word_last ? ST_FINISH : ST_DUMP_ADDR;
      ST_RUN_RST:   if (w_cyc_last) state_d = ST_RUN_EXEC;
      ST_RUN_EXEC:  if (w_cyc_last) state_d = ST_FINISH;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready    = (state_q == ST_IDLE);
    in_ready     = (state_q == ST_LOAD);
    out_valid    = (state_q == ST_DUMP_OUT);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_FINISH);
    CPU_Core_RST = (state_q != ST_RUN_EXEC);
  end

  // Debug-port address/write control. The A2 register is loaded on entry to
  // DUMP_ADDR so the address is already on the BRAM pins during that cycle.
  always_comb begin
    w_a2_load = 1'b0;
    w_a2_val  = addr_q;
    w_wr      = 1'b0;
    w_sel     = (state_q == ST_IDLE) ? cmd_sel : sel_q;
    case (state_q)
      ST_IDLE: begin
        if (w_cmd_fire && (cmd_op == DBG_DUMP) && (w_len != 13'd0)) begin
          w_a2_load = 1'b1;
          w_a2_val  = 32'd0;
        end
      end
      ST_LOAD: begin
        if (w_in_fire) begin
          w_a2_load = 1'b1;
          w_wr      = 1'b1;
        end
      end
      ST_DUMP_OUT: begin
        if (w_out_fire && !w_word_last) begin
          w_a2_load = 1'b1;
          w_a2_val  = addr_q + 32'd4;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      sel_q      <= 1'b0;
      len_q      <= 13'd0;
      addr_q     <= 32'd0;
      out_data_q <= 32'd0;
      d_a2_q     <= 32'd0;
      d_wd_q     <= 32'd0;
      d_we_q     <= 4'd0;
      i_a2_q     <= 32'd0;
      i_wd_q     <= 32'd0;
      i_we_q     <= 4'd0;
    end else begin
      if (w_cmd_fire) begin
        sel_q  <= cmd_sel;
        len_q  <= w_len;
        addr_q <= 32'd0;
      end
      if (w_in_fire || w_out_fire) begin
        addr_q <= addr_q + 32'd4;
      end
      if (state_q == ST_DUMP_WAIT) begin
        out_data_q <= sel_q ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;
      end
      if (w_a2_load && !w_sel) d_a2_q <= w_a2_val;
      if (w_a2_load &&  w_sel) i_a2_q <= w_a2_val;
      if (w_wr && !w_sel) d_wd_q <= in_data;
      if (w_wr &&  w_sel) i_wd_q <= in_data;
      d_we_q <= (w_wr && !w_sel) ? 4'b1111 : 4'b0000;
      i_we_q <= (w_wr &&  w_sel) ? 4'b1111 : 4'b0000;
    end
  end

  assign out_data              = out_data_q;
  assign CPU_Debug_DataRAM_A2  = d_a2_q;
  assign CPU_Debug_DataRAM_WD2 = d_wd_q;
  assign CPU_Debug_DataRAM_WE2 = d_we_q;
  assign CPU_Debug_InstRAM_A2  = i_a2_q;
  assign CPU_Debug_InstRAM_WD2 = i_wd_q;
  assign CPU_Debug_InstRAM_WE2 = i_we_q;

endmodule
`default_nettype wire
